// File: rtl/spi_slave_cfg_pkg.sv
// Shared constants for the parametrised SPI slave: defaults, field-stage codes, mode helpers.
package spi_slave_cfg_pkg;

  typedef logic [1:0] stage_t;

  localparam stage_t STAGE_IDLE    = 2'd0;
  localparam stage_t STAGE_CMD     = 2'd1;
  localparam stage_t STAGE_ADDR    = 2'd2;
  localparam stage_t STAGE_PAYLOAD = 2'd3;

  localparam int DEF_CMD_BITS     = 8;
  localparam int DEF_ADDR_BITS    = 8;
  localparam int DEF_PAYLOAD_BITS = 8;

  localparam int SPI_MODE_0 = 0;
  localparam int SPI_MODE_1 = 1;
  localparam int SPI_MODE_2 = 2;
  localparam int SPI_MODE_3 = 3;

  function automatic bit mode_cpol(input int mode);
    return (mode & 2) != 0;
  endfunction

  function automatic bit mode_cpha(input int mode);
    return (mode & 1) != 0;
  endfunction

  // Field a given bit index (0-based, within the frame) belongs to.
  function automatic stage_t stage_of(input int cnt, input int cmd_bits, input int addr_bits);
    if (cnt < cmd_bits)             return STAGE_CMD;
    if (cnt < cmd_bits + addr_bits) return STAGE_ADDR;
    return STAGE_PAYLOAD;
  endfunction

endpackage

// File: rtl/spi_slave_cfg_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall strobes aligned to the registered level.
module spi_slave_cfg_sync_edge #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  always_comb begin
    sync_d  = {sync_q[STAGES-2:0], d};
    level_d = sync_q[STAGES-1];
    rise_d  = sync_q[STAGES-1] & ~level_q;
    fall_d  = ~sync_q[STAGES-1] & level_q;
  end

  // Reset to the line's idle level so release of reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {STAGES{RESET_VAL}};
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_slave_cfg.sv
// SPI slave with per-instance {cmd, addr, payload} widths, all four modes, full-duplex MISO,
// abort detection and back-to-back frames under one chip select.
module spi_slave_cfg
  import spi_slave_cfg_pkg::*;
#(
  parameter int CMD_BITS     = DEF_CMD_BITS,
  parameter int ADDR_BITS    = DEF_ADDR_BITS,
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int SPI_MODE     = SPI_MODE_0,
  parameter int SYNC_STAGES  = 2,
  parameter int MSB_FIRST    = 1,
  localparam int FW          = CMD_BITS + ADDR_BITS + PAYLOAD_BITS
) (
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic                    sclk,
  input  logic                    cs,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  input  logic                    slv_tx_enb,
  input  logic [FW-1:0]           i_slv_frame,
  output logic [CMD_BITS-1:0]     o_cmd,
  output logic [ADDR_BITS-1:0]    o_addr,
  output logic [PAYLOAD_BITS-1:0] o_payload,
  output logic                    o_frame_valid,
  output logic                    o_frame_err,
  output logic                    o_busy,
  output logic [1:0]              o_stage
);

  localparam bit CPOL  = mode_cpol(SPI_MODE);
  localparam bit CPHA  = mode_cpha(SPI_MODE);
  localparam bit MSBF  = (MSB_FIRST != 0);
  localparam int CNT_W = $clog2(FW);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;

  spi_slave_cfg_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sclk_sync (
    .clk(sysclk), .rst_n(rst_n), .d(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_slave_cfg_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(sysclk), .rst_n(rst_n), .d(cs),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  // One extra flop versus the synchroniser depth keeps mosi aligned with the registered sclk strobes.
  logic [SYNC_STAGES:0] mosi_sync_q, mosi_sync_d;
  logic                 mosi_s;
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-1:0], mosi};
  assign mosi_s      = mosi_sync_q[SYNC_STAGES];

  // After an edge the level already shows the new value: leading edge leaves sclk away from CPOL.
  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  assign sclk_edge   = sclk_rise | sclk_fall;
  assign lead_edge   = sclk_edge & (sclk_lvl != CPOL);
  assign trail_edge  = sclk_edge & (sclk_lvl == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  function automatic logic tx_first(input logic [FW-1:0] v);
    return MSBF ? v[FW-1] : v[0];
  endfunction

  function automatic logic [FW-1:0] tx_advance(input logic [FW-1:0] v);
    return MSBF ? {v[FW-2:0], 1'b0} : {1'b0, v[FW-1:1]};
  endfunction

  stage_t                  stage_q, stage_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FW-1:0]           rx_q, rx_d;
  logic [FW-1:0]           tx_q, tx_d;
  logic                    miso_q, miso_d;
  logic [CMD_BITS-1:0]     cmd_q, cmd_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [PAYLOAD_BITS-1:0] payload_q, payload_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic [FW-1:0] tx_load;
  logic [FW-1:0] rx_shift;
  assign tx_load  = slv_tx_enb ? i_slv_frame : '0;
  assign rx_shift = MSBF ? {rx_q[FW-2:0], mosi_s} : {mosi_s, rx_q[FW-1:1]};

  always_comb begin
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    payload_d = payload_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (cs_rise) begin
      stage_d = STAGE_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
      err_d   = (stage_q != STAGE_IDLE) && (cnt_q != '0);
    end else if (cs_fall) begin
      stage_d = STAGE_CMD;
      cnt_d   = '0;
      tx_d    = tx_load;
      if (!CPHA) begin
        miso_d = tx_first(tx_load);
        tx_d   = tx_advance(tx_load);
      end
    end else if (stage_q != STAGE_IDLE) begin
      if (sample_edge) begin
        rx_d = rx_shift;
        if (cnt_q == CNT_W'(FW - 1)) begin
          cnt_d     = '0;
          cmd_d     = rx_shift[FW-1 -: CMD_BITS];
          addr_d    = rx_shift[PAYLOAD_BITS +: ADDR_BITS];
          payload_d = rx_shift[PAYLOAD_BITS-1:0];
          valid_d   = 1'b1;
          // Next frame's first bit goes out on the following shift edge.
          tx_d      = tx_load;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        stage_d = stage_of(int'(cnt_d), CMD_BITS, ADDR_BITS);
      end else if (shift_edge) begin
        miso_d = tx_first(tx_q);
        tx_d   = tx_advance(tx_q);
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
      stage_q     <= STAGE_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      cmd_q       <= '0;
      addr_q      <= '0;
      payload_q   <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      stage_q     <= stage_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      payload_q   <= payload_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign miso          = miso_q & ~cs_lvl;
  assign miso_oe       = ~cs_lvl;
  assign o_busy        = ~cs_lvl;
  assign o_cmd         = cmd_q;
  assign o_addr        = addr_q;
  assign o_payload     = payload_q;
  assign o_frame_valid = valid_q;
  assign o_frame_err   = err_q;
  assign o_stage       = stage_q;

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Directed bench: four 8/8/8 instances (one per SPI mode) plus a 4/12/16 LSB-first instance.
module tb_spi_slave_cfg;

  localparam int HALF = 64;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [4:0]  sclk_v = 5'b01100;
  logic [4:0]  cs_v   = 5'b11111;
  logic        mosi   = 1'b0;
  logic        tx_enb = 1'b0;
  logic [23:0] tx_frame = 24'h0;

  logic       miso_a [5];
  logic       oe_a   [5];
  logic       valid_a[5];
  logic       err_a  [5];
  logic       busy_a [5];
  logic [1:0] stage_a[5];
  logic [7:0] cmd_a  [4];
  logic [7:0] addr_a [4];
  logic [7:0] pay_a  [4];
  logic [3:0]  cmd4;
  logic [11:0] addr4;
  logic [15:0] pay4;

  int checks = 0;
  int failures = 0;
  int vcnt[5];
  int ecnt[5];

  always #4 sysclk = ~sysclk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mode
    spi_slave_cfg #(.SPI_MODE(gi)) u_dut (
      .sysclk(sysclk), .rst_n(rst_n), .sclk(sclk_v[gi]), .cs(cs_v[gi]), .mosi(mosi),
      .miso(miso_a[gi]), .miso_oe(oe_a[gi]), .slv_tx_enb(tx_enb), .i_slv_frame(tx_frame),
      .o_cmd(cmd_a[gi]), .o_addr(addr_a[gi]), .o_payload(pay_a[gi]),
      .o_frame_valid(valid_a[gi]), .o_frame_err(err_a[gi]), .o_busy(busy_a[gi]),
      .o_stage(stage_a[gi])
    );
  end

  spi_slave_cfg #(.CMD_BITS(4), .ADDR_BITS(12), .PAYLOAD_BITS(16), .MSB_FIRST(0)) u_dut_lsb (
    .sysclk(sysclk), .rst_n(rst_n), .sclk(sclk_v[4]), .cs(cs_v[4]), .mosi(mosi),
    .miso(miso_a[4]), .miso_oe(oe_a[4]), .slv_tx_enb(1'b0), .i_slv_frame(32'h0),
    .o_cmd(cmd4), .o_addr(addr4), .o_payload(pay4),
    .o_frame_valid(valid_a[4]), .o_frame_err(err_a[4]), .o_busy(busy_a[4]),
    .o_stage(stage_a[4])
  );

  initial begin
    for (int i = 0; i < 5; i++) begin
      vcnt[i] = 0;
      ecnt[i] = 0;
    end
  end

  always @(negedge sysclk) begin
    for (int i = 0; i < 5; i++) begin
      if (valid_a[i] === 1'b1) vcnt[i] = vcnt[i] + 1;
      if (err_a[i] === 1'b1)   ecnt[i] = ecnt[i] + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=%0h", tag, got);
    end
  endtask

  task automatic cs_low(input int idx);
    cs_v[idx] = 1'b0;
    #(20 * 8);
  endtask

  task automatic cs_high(input int idx);
    #(10 * 8);
    cs_v[idx] = 1'b1;
    #(20 * 8);
  endtask

  // Master side: drives mosi and captures miso at each sample edge.
  task automatic shift_bits(input int idx, input int n, input logic [63:0] data,
                            input bit lsb, output logic [63:0] cap);
    bit   cpha;
    logic b, m;
    cpha = (idx == 1) || (idx == 3);
    cap  = '0;
    for (int i = 0; i < n; i++) begin
      b = lsb ? data[i] : data[n-1-i];
      if (!cpha) begin
        mosi = b;
        #HALF;
        m = miso_a[idx];
        sclk_v[idx] = ~sclk_v[idx];
        #HALF;
        sclk_v[idx] = ~sclk_v[idx];
      end else begin
        sclk_v[idx] = ~sclk_v[idx];
        mosi = b;
        #HALF;
        m = miso_a[idx];
        sclk_v[idx] = ~sclk_v[idx];
        #HALF;
      end
      if (lsb) cap[i] = m;
      else     cap[n-1-i] = m;
    end
  endtask

  task automatic frame(input int idx, input int n, input logic [63:0] data,
                       input bit lsb, output logic [63:0] cap);
    cs_low(idx);
    shift_bits(idx, n, data, lsb, cap);
    cs_high(idx);
  endtask

  logic [63:0] cap;
  int v0, e0;

  initial begin
    #100;
    rst_n = 1'b1;
    #80;
    check("reset_cmd", 64'(cmd_a[0]), 64'h0);
    check("reset_stage", 64'(stage_a[0]), 64'h0);
    check("reset_miso_oe", 64'(oe_a[0]), 64'h0);
    check("reset_miso", 64'(miso_a[0]), 64'h0);
    check("reset_busy", 64'(busy_a[0]), 64'h0);

    // Mode 0, response disabled
    cs_low(0);
    check("busy_during_frame", 64'(busy_a[0]), 64'h1);
    check("oe_during_frame", 64'(oe_a[0]), 64'h1);
    shift_bits(0, 24, 64'h80A0D1, 1'b0, cap);
    cs_high(0);
    check("m0_cmd", 64'(cmd_a[0]), 64'h80);
    check("m0_addr", 64'(addr_a[0]), 64'hA0);
    check("m0_payload", 64'(pay_a[0]), 64'hD1);
    check("m0_valid_cnt", 64'(vcnt[0]), 64'd1);
    check("m0_err_cnt", 64'(ecnt[0]), 64'd0);
    check("m0_miso_zero", cap, 64'h0);

    // Modes 1..3 with response enabled
    tx_enb   = 1'b1;
    tx_frame = 24'h5A3CF0;
    for (int m = 1; m < 4; m++) begin
      frame(m, 24, 64'h80A0D1, 1'b0, cap);
      check($sformatf("m%0d_cmd", m), 64'(cmd_a[m]), 64'h80);
      check($sformatf("m%0d_addr", m), 64'(addr_a[m]), 64'hA0);
      check($sformatf("m%0d_payload", m), 64'(pay_a[m]), 64'hD1);
      check($sformatf("m%0d_miso", m), cap, 64'h5A3CF0);
      check($sformatf("m%0d_valid_cnt", m), 64'(vcnt[m]), 64'd1);
    end

    // LSB-first 4/12/16 instance
    frame(4, 32, 64'hB123BEEF, 1'b1, cap);
    check("lsb_cmd", 64'(cmd4), 64'hB);
    check("lsb_addr", 64'(addr4), 64'h123);
    check("lsb_payload", 64'(pay4), 64'hBEEF);
    check("lsb_valid_cnt", 64'(vcnt[4]), 64'd1);

    // Back-to-back frames under one cs, mode 0, response in both frames
    v0 = vcnt[0];
    frame(0, 48, 64'h010203_0A0B0C, 1'b0, cap);
    check("b2b_valid_cnt", 64'(vcnt[0] - v0), 64'd2);
    check("b2b_cmd", 64'(cmd_a[0]), 64'h0A);
    check("b2b_addr", 64'(addr_a[0]), 64'h0B);
    check("b2b_payload", 64'(pay_a[0]), 64'h0C);
    check("b2b_miso", cap, 64'h5A3CF0_5A3CF0);
    check("b2b_err_cnt", 64'(ecnt[0]), 64'd0);

    // Abort after 13 bits following a good frame
    tx_enb = 1'b0;
    frame(0, 24, 64'h80A0D1, 1'b0, cap);
    v0 = vcnt[0];
    e0 = ecnt[0];
    frame(0, 13, 64'h1FFF, 1'b0, cap);
    check("abort_err_cnt", 64'(ecnt[0] - e0), 64'd1);
    check("abort_valid_cnt", 64'(vcnt[0] - v0), 64'd0);
    check("abort_cmd", 64'(cmd_a[0]), 64'h80);
    check("abort_addr", 64'(addr_a[0]), 64'hA0);
    check("abort_payload", 64'(pay_a[0]), 64'hD1);
    check("abort_stage", 64'(stage_a[0]), 64'h0);

    // Reset mid-frame, then a clean frame
    v0 = vcnt[0];
    e0 = ecnt[0];
    cs_low(0);
    shift_bits(0, 10, 64'h3FF, 1'b0, cap);
    rst_n = 1'b0;
    #40;
    check("rst_mid_cmd", 64'(cmd_a[0]), 64'h0);
    check("rst_mid_stage", 64'(stage_a[0]), 64'h0);
    check("rst_mid_oe", 64'(oe_a[0]), 64'h0);
    cs_v[0] = 1'b1;
    #80;
    rst_n = 1'b1;
    #200;
    check("rst_no_valid", 64'(vcnt[0] - v0), 64'd0);
    check("rst_no_err", 64'(ecnt[0] - e0), 64'd0);
    frame(0, 24, 64'h112233, 1'b0, cap);
    check("post_rst_cmd", 64'(cmd_a[0]), 64'h11);
    check("post_rst_addr", 64'(addr_a[0]), 64'h22);
    check("post_rst_payload", 64'(pay_a[0]), 64'h33);
    check("post_rst_valid", 64'(vcnt[0] - v0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
